exec_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 9-bit core. It owns the program counter, latches each fetched word and presents it to the combinational control decoder. It stalls on data-memory LOAD/STORE until the memory acknowledges, and gates register-file commit. It also handles start/halt and run statistics for the top-level harness.

---
 rtl/exec_sequencer_pkg.sv | 21 ++
 rtl/exec_sequencer_sat.sv | 26 ++
 rtl/exec_sequencer.sv | 163 ++++++++++++++++
 tb/tb_exec_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_sequencer_pkg.sv
// exec_sequencer_pkg: definitions shared by the instruction sequencer and the
// files that import it.
//   seq_state_t  : sequencer FSM states
//   kHALT_INSTR  : instruction word that ends a run
//   kPC_W        : default program counter width
//   kINSTR_W     : instruction word width of the 9-bit core
package exec_sequencer_pkg;

   localparam int         kPC_W       = 10;
   localparam int         kINSTR_W    = 9;
   localparam logic [8:0] kHALT_INSTR = 9'h0FF;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      EXEC,
      MEM_WAIT,
      HALT
   } seq_state_t;

endpackage

// File: rtl/exec_sequencer_sat.sv
// sat_counter: clearable up-counter that sticks at all-ones.
//   gclk : clock, rising edge
//   grst : asynchronous active-high reset, clears the count
//   clr  : synchronous clear, wins over inc
//   inc  : count enable
//   cnt  : current count
module sat_counter #(
   parameter int W = 16
) (
   input  logic         gclk,
   input  logic         grst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge gclk or posedge grst) begin
      if (grst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle FETCH/EXEC sequencer for the 9-bit core.
// Owns the program counter, latches the fetched word for the decoder, stalls
// on data-memory LOAD/STORE until mem_ack, strobes register commit, and keeps
// run statistics.
//
// Ports:
//   Clk, Reset        : clock; asynchronous active-high reset
//   start             : begins a run from IDLE or HALT
//   instr_in          : ROM data at prog_counter
//   data_read_en      : decoder says LOAD
//   data_write_en     : decoder says STORE
//   branch_taken      : redirect request, valid in EXEC
//   branch_target     : absolute redirect address
//   mem_ack           : data memory completed the access
//   prog_counter      : ROM address
//   instr_out         : latched instruction for the decoder
//   mem_req           : data memory strobe, held until mem_ack
//   commit_en         : one-cycle register write qualifier per retirement
//   done / err        : run ended by HALT instruction / by memory timeout
//   cycle_cnt         : saturating count of FETCH/EXEC/MEM_WAIT cycles
//   retire_cnt        : saturating count of retired instructions
//
// Build option: SEQ_RETIRE_COUNT_EN enables the retire counter; without it
// retire_cnt reads as zero and no counter register exists.
module exec_sequencer
   import exec_sequencer_pkg::*;
#(
   parameter int PC_W     = kPC_W,
   parameter int CNT_W    = 16,
   parameter int WAIT_MAX = 15
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                start,
   input  logic [kINSTR_W-1:0] instr_in,
   input  logic                data_read_en,
   input  logic                data_write_en,
   input  logic                branch_taken,
   input  logic [PC_W-1:0]     branch_target,
   input  logic                mem_ack,
   output logic [PC_W-1:0]     prog_counter,
   output logic [kINSTR_W-1:0] instr_out,
   output logic                mem_req,
   output logic                commit_en,
   output logic                done,
   output logic                err,
   output logic [CNT_W-1:0]    cycle_cnt,
   output logic [CNT_W-1:0]    retire_cnt
);

   localparam int WAIT_W = $clog2(WAIT_MAX + 1);
   // Value the wait counter holds during the last allowed MEM_WAIT cycle.
   localparam logic [WAIT_W-1:0] kWAIT_LAST = WAIT_W'(WAIT_MAX - 1);

   seq_state_t        state;
   logic [WAIT_W-1:0] wait_cnt;

   logic is_halt, is_mem, in_exec, in_wait;
   logic exec_mem, exec_alu, wait_done, wait_tmo;
   logic run_clr, run_act;
   logic [PC_W-1:0] pc_seq, pc_next;

   assign is_halt   = (instr_out == kHALT_INSTR);
   assign is_mem    = data_read_en | data_write_en;
   assign in_exec   = (state == EXEC);
   assign in_wait   = (state == MEM_WAIT);
   assign exec_mem  = in_exec && !is_halt && is_mem;
   assign exec_alu  = in_exec && !is_halt && !is_mem;
   // An ack seen in EXEC is never a completion; only MEM_WAIT consumes it.
   assign wait_done = in_wait && mem_ack;
   assign wait_tmo  = in_wait && !mem_ack && (wait_cnt == kWAIT_LAST);

   // Reset gating makes the strobes drop in the same cycle Reset rises.
   assign mem_req   = !Reset && (exec_mem || in_wait);
   assign commit_en = !Reset && (exec_alu || wait_done);

   // Memory ops always fall through; only ALU/branch instructions redirect.
   assign pc_seq  = prog_counter + PC_W'(1);
   assign pc_next = (exec_alu && branch_taken) ? branch_target : pc_seq;

   assign run_clr = (state == IDLE) || ((state == HALT) && start);
   assign run_act = (state == FETCH) || in_exec || in_wait;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state        <= IDLE;
         prog_counter <= '0;
         instr_out    <= '0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               prog_counter <= '0;
               if (start) state <= FETCH;
            end
            FETCH: begin
               instr_out <= instr_in;
               state     <= EXEC;
            end
            EXEC: begin
               if (is_halt) begin
                  done  <= 1'b1;
                  state <= HALT;
               end else if (is_mem) begin
                  state <= MEM_WAIT;
               end else begin
                  prog_counter <= pc_next;
                  state        <= FETCH;
               end
            end
            MEM_WAIT: begin
               if (mem_ack) begin
                  prog_counter <= pc_next;
                  state        <= FETCH;
               end else if (wait_tmo) begin
                  err   <= 1'b1;
                  state <= HALT;
               end
            end
            HALT: begin
               if (start) begin
                  prog_counter <= '0;
                  done         <= 1'b0;
                  err          <= 1'b0;
                  state        <= FETCH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Held at zero outside MEM_WAIT, so every memory op starts from zero.
   sat_counter #(.W(WAIT_W)) u_wait_cnt (
      .gclk (Clk),
      .grst (Reset),
      .clr  (!in_wait),
      .inc  (in_wait && !mem_ack),
      .cnt  (wait_cnt)
   );

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .gclk (Clk),
      .grst (Reset),
      .clr  (run_clr),
      .inc  (run_act),
      .cnt  (cycle_cnt)
   );

`ifdef SEQ_RETIRE_COUNT_EN
   sat_counter #(.W(CNT_W)) u_retire_cnt (
      .gclk (Clk),
      .grst (Reset),
      .clr  (run_clr),
      .inc  (commit_en),
      .cnt  (retire_cnt)
   );
`else
   assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer. The bench plays ROM, decoder, branch unit and
// data memory from per-address tables. Before each run a program walker
// expands the same tables into the cycle-by-cycle outputs a run must show,
// and one compare process checks the DUT against that list every cycle.
// Counters are built 5 bits wide so that saturation is reachable.
module tb_exec_sequencer;
   import exec_sequencer_pkg::*;

   localparam int PW   = 10;
   localparam int CW   = 5;
   localparam int WM   = 15;
   localparam int CMAX = (1 << CW) - 1;

   logic          Clk = 1'b0;
   logic          Reset, start;
   logic [8:0]    instr_in, instr_out;
   logic          data_read_en, data_write_en, branch_taken, mem_ack;
   logic [PW-1:0] branch_target, prog_counter;
   logic          mem_req, commit_en, done, err;
   logic [CW-1:0] cycle_cnt, retire_cnt;

   exec_sequencer #(.PC_W(PW), .CNT_W(CW), .WAIT_MAX(WM)) dut (
      .Clk(Clk), .Reset(Reset), .start(start), .instr_in(instr_in),
      .data_read_en(data_read_en), .data_write_en(data_write_en),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .mem_ack(mem_ack), .prog_counter(prog_counter), .instr_out(instr_out),
      .mem_req(mem_req), .commit_en(commit_en), .done(done), .err(err),
      .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
   );

   always #5 Clk = ~Clk;

   // ---------------- environment tables ----------------
   localparam logic [8:0] NOP = 9'h080, LOAD = 9'h100, STORE = 9'h140;
   logic [8:0]    rom     [1024];
   int            ack_lat [1024];   // ack on this MEM_WAIT cycle, 0 = never
   logic          br_v    [1024];   // branch on first visit only
   logic [PW-1:0] br_t    [1024];
   logic          visited [1024];
   logic          ack_noise;        // also raise ack when no access is waiting
   int            mreq_k = 0;       // cycles mem_req has already been high

   assign instr_in      = rom[prog_counter];
   assign data_read_en  = (instr_out[8:6] == 3'b100);
   assign data_write_en = (instr_out[8:6] == 3'b101);
   assign branch_taken  = br_v[prog_counter] && !visited[prog_counter];
   assign branch_target = br_t[prog_counter];
   assign mem_ack = (mem_req && ack_lat[prog_counter] != 0 && mreq_k == ack_lat[prog_counter])
                    || (ack_noise && mreq_k == 0);

   always @(posedge Clk) begin
      mreq_k <= mem_req ? mreq_k + 1 : 0;
      if (commit_en && branch_taken) visited[prog_counter] <= 1'b1;
   end

   // ---------------- checking ----------------
   int total = 0, bad = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, got, exp);
      end
   endtask

   typedef struct {
      int pc; logic mr, cm, dn, er; int cyc, ret;
   } exp_t;
   exp_t exp_q[$];
   logic chk_en = 1'b0;
   int   n_mr, n_cm;

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   task automatic push(input int pc, input logic mr, cm, dn, er, input int cyc, ret);
      exp_t e;
      e.pc = pc; e.mr = mr; e.cm = cm; e.dn = dn; e.er = er;
      e.cyc = sat(cyc);
`ifdef SEQ_RETIRE_COUNT_EN
      e.ret = sat(ret);
`else
      e.ret = 0;
`endif
      exp_q.push_back(e);
   endtask

   // Walk the program one instruction at a time and list what each cycle of
   // the run must show, from the first FETCH up to a few cycles into HALT.
   task automatic build_trace();
      int   pc, cyc, ret;
      logic [8:0] ins;
      logic acked;
      logic vis [1024];
      pc = 0; cyc = 0; ret = 0;
      for (int i = 0; i < 1024; i++) vis[i] = 1'b0;
      for (int n = 0; n < 200; n++) begin
         ins = rom[pc];
         push(pc, 0, 0, 0, 0, cyc, ret); cyc++;                  // fetch
         if (ins == kHALT_INSTR) begin
            push(pc, 0, 0, 0, 0, cyc, ret); cyc++;
            repeat (3) push(pc, 0, 0, 1, 0, cyc, ret);
            return;
         end
         if (ins[8:6] == 3'b100 || ins[8:6] == 3'b101) begin
            acked = 1'b0;
            push(pc, 1, 0, 0, 0, cyc, ret); cyc++;               // request
            for (int j = 1; j <= WM; j++) begin
               if (ack_lat[pc] == j) begin
                  push(pc, 1, 1, 0, 0, cyc, ret); cyc++; ret++;
                  acked = 1'b1;
                  break;
               end
               push(pc, 1, 0, 0, 0, cyc, ret); cyc++;
            end
            if (!acked) begin
               repeat (3) push(pc, 0, 0, 0, 1, cyc, ret);
               return;
            end
            pc = (pc + 1) % 1024;
         end else begin
            push(pc, 0, 1, 0, 0, cyc, ret); cyc++; ret++;
            if (br_v[pc] && !vis[pc]) begin
               vis[pc] = 1'b1;
               pc = br_t[pc];
            end else begin
               pc = (pc + 1) % 1024;
            end
         end
      end
   endtask

   always @(negedge Clk) begin : cmp
      exp_t e;
      if (chk_en && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("pc",        prog_counter, e.pc);
         chk("mem_req",   mem_req,      e.mr);
         chk("commit_en", commit_en,    e.cm);
         chk("done",      done,         e.dn);
         chk("err",       err,          e.er);
         chk("cycle_cnt", cycle_cnt,    e.cyc);
         chk("retire_cnt", retire_cnt,  e.ret);
      end
      if (chk_en) begin
         n_mr += int'(mem_req);
         n_cm += int'(commit_en);
      end
   end

   task automatic clear_tables();
      for (int i = 0; i < 1024; i++) begin
         rom[i] = NOP; ack_lat[i] = 0; br_v[i] = 1'b0; br_t[i] = '0; visited[i] = 1'b0;
      end
      ack_noise = 1'b0;
   endtask

   // Start a run, optionally poke start during the first EXEC, and follow
   // the expected list to its end.
   task automatic run_prog(input bit midstart);
      build_trace();
      n_mr = 0; n_cm = 0;
      @(negedge Clk); start = 1'b1;
      @(posedge Clk); #1 start = 1'b0; chk_en = 1'b1;
      if (midstart) begin
         @(posedge Clk); #1 start = 1'b1;
         @(posedge Clk); #1 start = 1'b0;
      end
      for (int c = 0; c < 500; c++) begin
         @(negedge Clk); #1;
         if (exp_q.size() == 0) break;
      end
      chk("run_end_pending", exp_q.size(), 0);
      chk_en = 1'b0;
      exp_q.delete();
   endtask

`ifdef SEQ_RETIRE_COUNT_EN
   localparam bit RET_ON = 1'b1;
`else
   localparam bit RET_ON = 1'b0;
`endif

   initial begin
      Reset = 1'b1; start = 1'b0;
      clear_tables();
      repeat (2) @(negedge Clk);
      chk("rst_pc", prog_counter, 0);
      chk("rst_instr", instr_out, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_commit", commit_en, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_cycle", cycle_cnt, 0);
      chk("rst_retire", retire_cnt, 0);
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
      chk("idle_cycle", cycle_cnt, 0);

      // basic: one ALU op then HALT
      rom[0] = NOP; rom[1] = kHALT_INSTR;
      run_prog(0);
      chk("a_done", done, 1);
      chk("a_cycle", cycle_cnt, 4);
      chk("a_retire", retire_cnt, RET_ON ? 1 : 0);
      chk("a_commits", n_cm, 1);

      // LOAD acked on the third wait cycle; its branch request is ignored
      clear_tables();
      rom[0] = LOAD; ack_lat[0] = 3; br_v[0] = 1'b1; br_t[0] = 10'h200;
      rom[1] = kHALT_INSTR;
      run_prog(0);
      chk("b_mem_req_cycles", n_mr, 4);
      chk("b_commits", n_cm, 1);
      chk("b_pc", prog_counter, 1);
      chk("b_done", done, 1);

      // branch 5 -> 0x3F0, run off the top, wrap to 0, halt at 6
      clear_tables();
      br_v[5] = 1'b1; br_t[5] = 10'h3F0; rom[6] = kHALT_INSTR;
      run_prog(0);
      chk("c_pc", prog_counter, 6);
      chk("c_cycle_sat", cycle_cnt, CMAX);
      chk("c_retire", retire_cnt, RET_ON ? 28 : 0);

      // STORE never acked: timeout after WM wait cycles
      clear_tables();
      rom[0] = STORE;
      run_prog(0);
      chk("d_err", err, 1);
      chk("d_done", done, 0);
      chk("d_cycle", cycle_cnt, 17);
      chk("d_commits", n_cm, 0);
      chk("d_mem_req_cycles", n_mr, 16);
      chk("d_mem_req_halt", mem_req, 0);

      // ack on the limit cycle wins; stray acks outside a wait are ignored
      clear_tables();
      rom[0] = LOAD; ack_lat[0] = WM;
      rom[1] = STORE; ack_lat[1] = 1;
      rom[2] = kHALT_INSTR;
      ack_noise = 1'b1;
      run_prog(0);
      chk("e_err", err, 0);
      chk("e_done", done, 1);
      chk("e_commits", n_cm, 2);
      chk("e_mem_req_cycles", n_mr, 18);

      // Reset in the middle of MEM_WAIT
      clear_tables();
      rom[0] = STORE;
      @(negedge Clk); start = 1'b1;
      @(posedge Clk); #1 start = 1'b0;
      repeat (4) @(posedge Clk);
      #2;
      chk("f_mem_req_pre", mem_req, 1);
      Reset = 1'b1;
      #1;
      chk("f_mem_req_rst", mem_req, 0);
      chk("f_commit_rst", commit_en, 0);
      chk("f_pc_rst", prog_counter, 0);
      chk("f_cycle_rst", cycle_cnt, 0);
      @(negedge Clk); Reset = 1'b0;
      @(negedge Clk);
      chk("f_mem_req_idle", mem_req, 0);

      // restart after reset, with a start pulse landing in EXEC
      clear_tables();
      rom[0] = NOP; rom[1] = kHALT_INSTR;
      run_prog(1);
      chk("g_done", done, 1);
      chk("g_cycle", cycle_cnt, 4);

      // start from HALT restarts cleanly
      run_prog(0);
      chk("h_done", done, 1);
      chk("h_commits", n_cm, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
